// File: rtl/i8088_bus_sequencer_if.sv
// 8088 bus / AXI4-Lite bundle for i8088_bus_sequencer.
// master: sequencer view (drives READY, data-out and the AXI master side).
// slave:  CPU-pins plus AXI-slave view (bench or bus model).
interface i8088_bus_sequencer_if;
  // CPU side
  logic        I8088_CLK_RISE;
  logic [19:0] A;
  logic [7:0]  AD8_in;
  logic        nRD;
  logic        nWR;
  logic        IO_nM;
  logic        ALE;
  logic        READY;
  logic [7:0]  AD8_out;
  logic        AD8_enout;
  // AXI4-Lite read
  logic [31:0] AXI_araddr;
  logic [2:0]  AXI_arprot;
  logic        AXI_arvalid;
  logic        AXI_arready;
  logic [31:0] AXI_rdata;
  logic [1:0]  AXI_rresp;
  logic        AXI_rvalid;
  logic        AXI_rready;
  // AXI4-Lite write
  logic [31:0] AXI_awaddr;
  logic [2:0]  AXI_awprot;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic [31:0] AXI_wdata;
  logic [3:0]  AXI_wstrb;
  logic        AXI_wvalid;
  logic        AXI_wready;
  logic [1:0]  AXI_bresp;
  logic        AXI_bvalid;
  logic        AXI_bready;

  modport master (
    input  I8088_CLK_RISE, A, AD8_in, nRD, nWR, IO_nM, ALE,
    output READY, AD8_out, AD8_enout,
    output AXI_araddr, AXI_arprot, AXI_arvalid,
    input  AXI_arready,
    input  AXI_rdata, AXI_rresp, AXI_rvalid,
    output AXI_rready,
    output AXI_awaddr, AXI_awprot, AXI_awvalid,
    input  AXI_awready,
    output AXI_wdata, AXI_wstrb, AXI_wvalid,
    input  AXI_wready,
    input  AXI_bresp, AXI_bvalid,
    output AXI_bready
  );

  modport slave (
    output I8088_CLK_RISE, A, AD8_in, nRD, nWR, IO_nM, ALE,
    input  READY, AD8_out, AD8_enout,
    input  AXI_araddr, AXI_arprot, AXI_arvalid,
    output AXI_arready,
    output AXI_rdata, AXI_rresp, AXI_rvalid,
    input  AXI_rready,
    input  AXI_awaddr, AXI_awprot, AXI_awvalid,
    output AXI_awready,
    input  AXI_wdata, AXI_wstrb, AXI_wvalid,
    output AXI_wready,
    output AXI_bresp, AXI_bvalid,
    input  AXI_bready
  );
endinterface

// File: rtl/i8088_bus_sequencer.sv
// i8088_bus_sequencer: turns sampled 8088 bus cycles into single AXI4-Lite
// transactions, holding the CPU in wait states until the AXI side completes.
// Optional macro I8088_BUS_TIMEOUT_EN adds a per-transaction watchdog that
// abandons a stuck AXI transfer after TIMEOUT_CYCLES clocks.
module i8088_bus_sequencer #(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter logic [31:0] IO_BASE        = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic                   AXI_CLK,
  input logic                   RESETN,
  i8088_bus_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DRIVE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        enout_q, enout_d;
  logic [7:0]  dout_q, dout_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;

  logic [31:0] cpu_addr;
  logic        in_rd, in_wr;
  logic        tmo_hit;

  // Responses carry no information the CPU can use; errors complete normally.
  logic unused_resp;
  assign unused_resp = ^{bus.AXI_rresp, bus.AXI_bresp};

  // Word-aligned AXI address for the current CPU cycle; byte lane picked separately.
  assign cpu_addr = bus.IO_nM ? (IO_BASE  + {16'h0, bus.A[15:2], 2'b00})
                              : (MEM_BASE + {12'h0, bus.A[19:2], 2'b00});

  assign in_rd = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign in_wr = (state_q == WR_REQ) || (state_q == WR_WAIT);

  function automatic logic [7:0] lane_byte(logic [31:0] w, logic [1:0] l);
    case (l)
      2'd0:    lane_byte = w[7:0];
      2'd1:    lane_byte = w[15:8];
      2'd2:    lane_byte = w[23:16];
      default: lane_byte = w[31:24];
    endcase
  endfunction

`ifdef I8088_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit = (in_rd || in_wr) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts when a transfer is launched, counts while it is in flight.
  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN)
      tmo_cnt_q <= '0;
    else if (state_q == IDLE && (state_d == RD_REQ || state_d == WR_REQ))
      tmo_cnt_q <= '0;
    else if (in_rd || in_wr)
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      enout_q   <= 1'b0;
      dout_q    <= 8'h00;
      addr_q    <= '0;
      lane_q    <= '0;
      wbyte_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      enout_q   <= enout_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      wbyte_q   <= wbyte_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  // Next state and next register values; everything holds unless a rule fires.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    enout_d   = enout_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    wbyte_d   = wbyte_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;

    case (state_q)
      IDLE: if (bus.I8088_CLK_RISE) begin
        if (bus.ALE) ready_d = 1'b0;
        if (!bus.nRD && !bus.nWR) begin
          // Contradictory strobes: release the CPU without touching AXI.
          ready_d = 1'b1;
          state_d = DONE;
        end else if (!bus.nRD) begin
          addr_d    = cpu_addr;
          lane_d    = bus.A[1:0];
          arvalid_d = 1'b1;
          ready_d   = 1'b0;
          state_d   = RD_REQ;
        end else if (!bus.nWR) begin
          addr_d    = cpu_addr;
          lane_d    = bus.A[1:0];
          wbyte_d   = bus.AD8_in;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          ready_d   = 1'b0;
          state_d   = WR_REQ;
        end
      end
      RD_REQ: if (bus.AXI_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (bus.AXI_rvalid) begin
        dout_d   = lane_byte(bus.AXI_rdata, lane_q);
        ready_d  = 1'b1;
        enout_d  = 1'b1;
        rready_d = 1'b0;
        state_d  = DRIVE;
      end
      WR_REQ: begin
        // AW and W complete independently; move on once both are done.
        if (bus.AXI_awready) awvalid_d = 1'b0;
        if (bus.AXI_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || bus.AXI_awready) && (!wvalid_q || bus.AXI_wready)) begin
          bready_d = 1'b1;
          state_d  = WR_WAIT;
        end
      end
      WR_WAIT: if (bus.AXI_bvalid) begin
        ready_d  = 1'b1;
        bready_d = 1'b0;
        state_d  = DONE;
      end
      DRIVE, DONE: if (bus.I8088_CLK_RISE && bus.nRD && bus.nWR) begin
        enout_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only wins if the transfer did not finish on this same clock.
    if (tmo_hit && (state_d == RD_REQ || state_d == RD_WAIT ||
                    state_d == WR_REQ || state_d == WR_WAIT)) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      ready_d   = 1'b1;
      if (in_rd) begin
        dout_d  = 8'hFF;
        enout_d = 1'b1;
        state_d = DRIVE;
      end else begin
        state_d = DONE;
      end
    end
  end

  assign bus.READY       = ready_q;
  assign bus.AD8_out     = dout_q;
  assign bus.AD8_enout   = enout_q;
  assign bus.AXI_araddr  = addr_q;
  assign bus.AXI_arprot  = 3'b000;
  assign bus.AXI_arvalid = arvalid_q;
  assign bus.AXI_rready  = rready_q;
  assign bus.AXI_awaddr  = addr_q;
  assign bus.AXI_awprot  = 3'b000;
  assign bus.AXI_awvalid = awvalid_q;
  assign bus.AXI_wdata   = {4{wbyte_q}};
  assign bus.AXI_wstrb   = 4'b0001 << lane_q;
  assign bus.AXI_wvalid  = wvalid_q;
  assign bus.AXI_bready  = bready_q;

endmodule

// File: tb/tb_i8088_bus_sequencer.sv
// Bench for i8088_bus_sequencer: directed bus cycles plus randomized
// reads/writes against an arithmetic reference model and a delay-programmable
// AXI4-Lite slave. Define I8088_BUS_TIMEOUT_EN to exercise the watchdog.
module tb_i8088_bus_sequencer;

  localparam logic [31:0] MEM_B = 32'h0000_0000;
  localparam logic [31:0] IO_B  = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  i8088_bus_sequencer_if bus ();

  i8088_bus_sequencer #(
    .MEM_BASE(MEM_B), .IO_BASE(IO_B), .TIMEOUT_CYCLES(16)
  ) dut (
    .AXI_CLK(clk), .RESETN(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // slave configuration (written by the main process only)
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit          ar_never = 0;
  logic [31:0] cur_rdata = '0;
  int          flush_req = 0;
  // slave observations (written by the slave process only)
  int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
  int          ar_vis = 0, aw_vis = 0;
  logic [31:0] last_ar = '0, last_aw = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // AXI4-Lite slave: evaluated once per clock, just after the edge.
  initial begin
    bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
    bit r_pend = 0, aw_got = 0, w_got = 0, b_arm = 0;
    int ar_cnt = -1, r_cnt = 0, aw_cnt = -1, w_cnt = -1, b_cnt = 0, flush_ack = 0;
    logic [31:0] cap_ar = '0, cap_aw = '0, cap_wd = '0;
    logic [3:0]  cap_ws = '0;
    bus.AXI_arready = 0; bus.AXI_rvalid = 0; bus.AXI_rdata = '0; bus.AXI_rresp = 2'b00;
    bus.AXI_awready = 0; bus.AXI_wready = 0; bus.AXI_bvalid = 0; bus.AXI_bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (flush_ack != flush_req) begin
        flush_ack = flush_req;
        bus.AXI_arready = 0; bus.AXI_rvalid = 0; bus.AXI_awready = 0;
        bus.AXI_wready = 0; bus.AXI_bvalid = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_arm = 0;
        ar_cnt = -1; aw_cnt = -1; w_cnt = -1;
        continue;
      end
      if (bus.AXI_arvalid) ar_vis++;
      if (bus.AXI_awvalid) aw_vis++;
      // read address
      if (hs_ar) begin
        bus.AXI_arready = 0; last_ar = cap_ar; n_ar++;
        r_pend = 1; r_cnt = r_dly;
      end else if (bus.AXI_arvalid && !bus.AXI_arready && !ar_never) begin
        if (ar_cnt < 0) ar_cnt = ar_dly;
        if (ar_cnt == 0) begin bus.AXI_arready = 1; cap_ar = bus.AXI_araddr; ar_cnt = -1; end
        else ar_cnt--;
      end
      // read data (rresp error: must not matter)
      if (hs_r) begin
        bus.AXI_rvalid = 0; r_pend = 0; n_r++;
      end else if (r_pend && !bus.AXI_rvalid) begin
        if (r_cnt == 0) begin
          bus.AXI_rvalid = 1; bus.AXI_rdata = cur_rdata; bus.AXI_rresp = 2'($urandom_range(0, 3));
        end else r_cnt--;
      end
      // write address
      if (hs_aw) begin
        bus.AXI_awready = 0; last_aw = cap_aw; aw_got = 1; n_aw++;
      end else if (bus.AXI_awvalid && !bus.AXI_awready) begin
        if (aw_cnt < 0) aw_cnt = aw_dly;
        if (aw_cnt == 0) begin bus.AXI_awready = 1; cap_aw = bus.AXI_awaddr; aw_cnt = -1; end
        else aw_cnt--;
      end
      // write data
      if (hs_w) begin
        bus.AXI_wready = 0; last_wdata = cap_wd; last_wstrb = cap_ws; w_got = 1; n_w++;
      end else if (bus.AXI_wvalid && !bus.AXI_wready) begin
        if (w_cnt < 0) w_cnt = w_dly;
        if (w_cnt == 0) begin
          bus.AXI_wready = 1; cap_wd = bus.AXI_wdata; cap_ws = bus.AXI_wstrb; w_cnt = -1;
        end else w_cnt--;
      end
      // write response
      if (hs_b) begin
        bus.AXI_bvalid = 0; aw_got = 0; w_got = 0; b_arm = 0; n_b++;
      end else if (aw_got && w_got && !bus.AXI_bvalid) begin
        if (!b_arm) begin b_arm = 1; b_cnt = b_dly; end
        if (b_cnt == 0) begin bus.AXI_bvalid = 1; bus.AXI_bresp = 2'($urandom_range(0, 3)); end
        else b_cnt--;
      end
      hs_ar = bus.AXI_arvalid && bus.AXI_arready;
      hs_r  = bus.AXI_rvalid  && bus.AXI_rready;
      hs_aw = bus.AXI_awvalid && bus.AXI_awready;
      hs_w  = bus.AXI_wvalid  && bus.AXI_wready;
      hs_b  = bus.AXI_bvalid  && bus.AXI_bready;
    end
  end

  // Reference model: spec address map and lane rules in plain arithmetic.
  function automatic logic [31:0] ref_addr(input bit io, input logic [19:0] a);
    logic [31:0] av = {12'h0, a};
    if (io) return IO_B + ((av % 32'h1_0000) / 4 * 4);
    return MEM_B + (av / 4 * 4);
  endfunction

  // One-clock CPU edge strobe; returns 3 time units after the sampling edge.
  task automatic rise_pulse();
    @(posedge clk); #2; bus.I8088_CLK_RISE = 1;
    @(posedge clk); #2; bus.I8088_CLK_RISE = 0;
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (bus.READY !== 1'b1 && cyc < 300) begin @(posedge clk); #3; cyc++; end
    chk(tag, 32'(cyc < 300), 1);
  endtask

  task automatic do_read(input bit io, input logic [19:0] a, input logic [31:0] rd,
                         input int ard, input int rdl,
                         output logic [31:0] got_addr, output logic [7:0] got_byte);
    logic [7:0] exp_b = 8'((rd / (32'd1 << (8 * 32'(a % 4)))) % 256);
    int n0 = n_r, a0 = n_ar;
    ar_dly = ard; r_dly = rdl; cur_rdata = rd;
    bus.A = a; bus.IO_nM = io; bus.ALE = 1;
    rise_pulse();
    bus.ALE = 0;
    chk("ale_ready_low", bus.READY, 0);
    bus.nRD = 0;
    rise_pulse();
    chk("rd_ready_low", bus.READY, 0);
    wait_ready("rd_complete");
    chk("rd_one_r_before_ready", n_r, n0 + 1);
    chk("rd_one_ar", n_ar, a0 + 1);
    chk("rd_araddr", last_ar, ref_addr(io, a));
    chk("rd_byte", bus.AD8_out, exp_b);
    chk("rd_enout", bus.AD8_enout, 1);
    got_addr = last_ar; got_byte = bus.AD8_out;
    rise_pulse();
    chk("rd_enout_held", bus.AD8_enout, 1);
    bus.nRD = 1;
    rise_pulse();
    chk("rd_release", bus.AD8_enout, 0);
    chk("rd_out_held", bus.AD8_out, exp_b);
  endtask

  task automatic do_write(input bit io, input logic [19:0] a, input logic [7:0] d,
                          input int awd, input int wd, input int bd,
                          output logic [31:0] got_addr, output logic [31:0] got_wd,
                          output logic [3:0] got_ws);
    int nb = n_b, naw = n_aw, nw = n_w;
    aw_dly = awd; w_dly = wd; b_dly = bd;
    bus.A = a; bus.IO_nM = io; bus.AD8_in = d; bus.ALE = 1;
    rise_pulse();
    bus.ALE = 0;
    chk("ale_ready_low", bus.READY, 0);
    bus.nWR = 0;
    rise_pulse();
    bus.AD8_in = 8'($urandom);
    wait_ready("wr_complete");
    chk("wr_one_b_before_ready", n_b, nb + 1);
    chk("wr_one_aw", n_aw, naw + 1);
    chk("wr_one_w", n_w, nw + 1);
    chk("wr_awaddr", last_aw, ref_addr(io, a));
    chk("wr_wdata", last_wdata, 32'(d) * 32'h0101_0101);
    chk("wr_wstrb", 32'(last_wstrb), 32'd1 << (a % 4));
    chk("wr_enout", bus.AD8_enout, 0);
    got_addr = last_aw; got_wd = last_wdata; got_ws = last_wstrb;
    bus.nWR = 1;
    rise_pulse();
    chk("wr_idle_ready", bus.READY, 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #3; rst_n = 0;
    #1;
    chk("rst_arvalid", bus.AXI_arvalid, 0);
    chk("rst_rready", bus.AXI_rready, 0);
    chk("rst_awvalid", bus.AXI_awvalid, 0);
    chk("rst_ready", bus.READY, 1);
    chk("rst_enout", bus.AD8_enout, 0);
    chk("rst_dout", bus.AD8_out, 0);
    flush_req++;
    bus.nRD = 1; bus.nWR = 1; bus.ALE = 0;
    #1; rst_n = 1;
  endtask

  initial begin
    logic [31:0] ga, gw;
    logic [7:0]  gb;
    logic [3:0]  gs;
    int v0, a0, cyc;
    bus.I8088_CLK_RISE = 0; bus.A = '0; bus.AD8_in = '0;
    bus.nRD = 1; bus.nWR = 1; bus.IO_nM = 0; bus.ALE = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_ready", bus.READY, 1);
    chk("reset_enout", bus.AD8_enout, 0);
    chk("reset_dout", bus.AD8_out, 0);
    chk("reset_valids", {bus.AXI_arvalid, bus.AXI_awvalid, bus.AXI_wvalid}, 0);
    chk("reset_readys", {bus.AXI_rready, bus.AXI_bready}, 0);
    rst_n = 1;

    // memory read, lane 1, slow data
    do_read(0, 20'hF_FFF1, 32'hAABB_CCDD, 0, 5, ga, gb);
    chk("mem_rd_addr_lit", ga, 32'h000F_FFF0);
    chk("mem_rd_byte_lit", gb, 8'hCC);

    // I/O write, AW three cycles behind W
    do_write(1, 20'h0_03F8, 8'h5A, 3, 0, 1, ga, gw, gs);
    chk("io_wr_addr_lit", ga, 32'h1000_03F8);
    chk("io_wr_wdata_lit", gw, 32'h5A5A_5A5A);
    chk("io_wr_wstrb_lit", gs, 4'b0001);

    // both strobes low together: no AXI traffic, READY released
    v0 = ar_vis + aw_vis;
    bus.A = 20'h1_2345; bus.ALE = 1;
    rise_pulse();
    bus.ALE = 0;
    chk("both_ale_ready", bus.READY, 0);
    bus.nRD = 0; bus.nWR = 0;
    rise_pulse();
    chk("both_ready", bus.READY, 1);
    repeat (6) @(posedge clk);
    #3;
    chk("both_no_axi", ar_vis + aw_vis, v0);
    bus.nRD = 1; bus.nWR = 1;
    rise_pulse();
    chk("both_idle_ready", bus.READY, 1);

    // reset while waiting for read data, then a clean read
    a0 = n_ar;
    r_dly = 30; ar_dly = 0; cur_rdata = 32'h1122_3344;
    bus.A = 20'h0_0102; bus.IO_nM = 0; bus.ALE = 1;
    rise_pulse();
    bus.ALE = 0; bus.nRD = 0;
    rise_pulse();
    cyc = 0;
    while (n_ar == a0 && cyc < 50) begin @(posedge clk); #3; cyc++; end
    chk("rst_mid_ar_seen", 32'(cyc < 50), 1);
    chk("rst_mid_rready", bus.AXI_rready, 1);
    reset_pulse();
    do_read(0, 20'h0_0102, 32'h1122_3344, 1, 2, ga, gb);
    chk("post_rst_byte_lit", gb, 8'h22);

    // slave never takes the read address
    ar_never = 1;
    bus.A = 20'h0_4000; bus.IO_nM = 0; bus.ALE = 1;
    rise_pulse();
    bus.ALE = 0; bus.nRD = 0;
    rise_pulse();
`ifdef I8088_BUS_TIMEOUT_EN
    repeat (15) begin @(posedge clk); #3; end
    chk("tmo_ready_before", bus.READY, 0);
    @(posedge clk); #3;
    chk("tmo_ready", bus.READY, 1);
    chk("tmo_dout", bus.AD8_out, 8'hFF);
    chk("tmo_enout", bus.AD8_enout, 1);
    chk("tmo_arvalid", bus.AXI_arvalid, 0);
`else
    repeat (40) begin @(posedge clk); #3; end
    chk("stall_ready", bus.READY, 0);
    chk("stall_arvalid", bus.AXI_arvalid, 1);
`endif
    reset_pulse();
    ar_never = 0;

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      bit          wr = 1'($urandom_range(0, 1));
      bit          io = 1'($urandom_range(0, 1));
      logic [19:0] a  = 20'($urandom);
      if (wr)
        do_write(io, a, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3), ga, gw, gs);
      else
        do_read(io, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4), ga, gb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
